// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package inst_prefetch_buffer_pkg;

  localparam int          INST_W           = 32;
  localparam int          ADDR_INCR        = 4;
  localparam logic [31:0] DEFAULT_RST_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Bit 31 is the supervisor bit and survives the increment; [30:0] wraps.
  function automatic logic [INST_W-1:0] next_fetch_addr(input logic [INST_W-1:0] addr);
    return {addr[INST_W-1], addr[INST_W-2:0] + (INST_W-1)'(ADDR_INCR)};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Circular instruction queue: DEPTH entries of {data, address} with push, pop and flush.
module prefetch_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int ENTRY_W = 2 * INST_W,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_data,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [ENTRY_W-1:0] o_head,
  output logic [CNT_W-1:0]   o_count
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_push;
  logic               w_pop;
  logic               w_full;

  // Flush wins over both push and pop in the same cycle.
  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && !i_flush && (r_count != '0);
  assign w_full = (r_count == CNT_W'(DEPTH));

  // NOTE: storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: keeps one memory read in flight and queues returned words for the core.
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter logic [31:0] RstAddr = DEFAULT_RST_ADDR,
  parameter int          DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect,
  input  logic [INST_W-1:0] i_redirect_addr,
  output logic              o_inst_valid,
  output logic [INST_W-1:0] o_inst_data,
  output logic [INST_W-1:0] o_inst_addr,
  input  logic              i_inst_ready,
  output logic              o_mem_req,
  output logic [INST_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [INST_W-1:0] i_mem_rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [INST_W-1:0]   r_fetch_addr;
  logic [INST_W-1:0]   w_fetch_nxt;
  logic [INST_W-1:0]   r_mem_addr;
  logic [INST_W-1:0]   w_redirect_addr;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W-1:0]    w_count;
  logic [2*INST_W-1:0] w_head;
  logic                w_unused_addr_bits;

  assign w_redirect_addr    = {i_redirect_addr[INST_W-1:2], 2'b00};
  assign w_unused_addr_bits = ^i_redirect_addr[1:0];

  // Redirect discards the head, so a pop in the redirect cycle is suppressed.
  assign w_pop = o_inst_valid && i_inst_ready && !i_redirect;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_nxt = r_fetch_addr;
    w_push      = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_redirect) begin
          w_fetch_nxt = w_redirect_addr;
          w_issue     = 1'b1;
        end else begin
          w_issue = (w_count < CNT_W'(DEPTH));
        end
      end
      ST_REQ: begin
        if (i_mem_ack) begin
          w_state_nxt = ST_IDLE;
          if (i_redirect) begin
            w_fetch_nxt = w_redirect_addr;
            w_issue     = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_fetch_nxt = next_fetch_addr(r_fetch_addr);
            w_issue     = (w_count < CNT_W'(DEPTH - 1));
          end
        end else if (i_redirect) begin
          w_fetch_nxt = w_redirect_addr;
          w_state_nxt = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        // The stale response is dropped; the queue was already flushed, so reissue is always allowed.
        if (i_redirect) w_fetch_nxt = w_redirect_addr;
        if (i_mem_ack)  w_issue     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_issue) w_state_nxt = ST_REQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= RstAddr;
      r_mem_addr   <= RstAddr;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_nxt;
      if (w_issue) r_mem_addr <= w_fetch_nxt;
    end
  end

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (2 * INST_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({i_mem_rdata, r_mem_addr}),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign o_mem_req    = (r_state != ST_IDLE);
  assign o_mem_addr   = r_mem_addr;
  assign o_inst_valid = (w_count != '0);
  assign o_inst_data  = w_head[2*INST_W-1:INST_W];
  assign o_inst_addr  = w_head[INST_W-1:0];

endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 Parameter RstAddr, default 32'h80000000, SHALL set the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, SHALL set the instruction queue capacity (power of two, minimum 2).
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 redirect  in  1  the core requests a fetch-stream restart.
REQ-007 redirect_addr  in  32  restart target; bits [1:0] forced to 0.
REQ-008 inst_valid  out  1  queue head holds a valid instruction.
REQ-009 inst_data  out  32  queue-head instruction word.
REQ-010 inst_addr  out  32  address of the queue-head instruction.
REQ-011 inst_ready  in  1  the core consumes the head when it is high together with inst_valid.
REQ-012 mem_req  out  1  instruction-memory read request.
REQ-013 mem_addr  out  32  word-aligned read address.
REQ-014 mem_ack  in  1  read data is valid this cycle; sampled only while mem_req is high.
REQ-015 mem_rdata  in  32  read data.

Function
REQ-016 The block SHALL run an FSM with states IDLE, REQ and DISCARD.
REQ-017 IDLE -> REQ SHALL occur when no redirect is present and (entry count + 0) < DEPTH; mem_req is asserted the following cycle, with mem_addr = fetch_addr.
REQ-018 In REQ, mem_req and mem_addr SHALL stay stable until mem_ack; at most one request is outstanding.
REQ-019 On mem_ack in REQ, the block SHALL write {mem_rdata, mem_addr} to the queue tail, increment count and advance fetch_addr; it goes to REQ again if count+1 < DEPTH, otherwise to IDLE.
REQ-020 The address increment SHALL be {fetch_addr[31], fetch_addr[30:0]+4}: bit 31 (supervisor) is preserved and [30:0] wraps modulo 2^31.
REQ-021 Write-to-visible latency SHALL be 1 cycle: inst_valid rises the cycle after mem_ack. There is no combinational bypass from mem_rdata to inst_data.
REQ-022 A pop (inst_valid && inst_ready) SHALL remove the head. A push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 The issue rule SHALL guarantee that a push never finds the queue full; a push while full is a design error and SHALL be flagged by an assertion.
REQ-024 inst_valid SHALL equal (count != 0). inst_data and inst_addr SHALL be don't-care while inst_valid is low.
REQ-025 Redirect SHALL have priority over push and pop in its cycle. count becomes 0 next cycle, and fetch_addr becomes redirect_addr & 32'hFFFFFFFC.
REQ-026 Redirect in IDLE, or in REQ with mem_ack in the same cycle, SHALL go to REQ (or IDLE if DEPTH rule fails); that ack data is dropped.
REQ-027 Redirect in REQ without mem_ack SHALL go to DISCARD. DISCARD keeps mem_req/mem_addr of the old request until mem_ack, drops that data, then issues at the new fetch_addr.
REQ-028 A further redirect in DISCARD SHALL update fetch_addr only; the last redirect wins.
REQ-029 The block SHALL never deassert mem_req before mem_ack once it has been asserted.

Reset
REQ-030 While RESET is low, the block SHALL force: state=IDLE, count=0, head/tail pointers=0, fetch_addr=RstAddr, mem_req=0, mem_addr=RstAddr, inst_valid=0.
REQ-031 Reset asserted mid-request SHALL abandon the request immediately. The memory side tolerates mem_req dropping under reset.
REQ-032 The first mem_req SHALL assert on the first rising edge after RESET deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef (IDLE/REQ/DISCARD), INST_W=32, ADDR_INCR=4 and the default RstAddr.
REQ-034 Queue storage SHALL be one sub-module, prefetch_fifo. It is DEPTH x 64 bits (data + address), with push/pop/flush and count output.

Verification
REQ-035 Reset release, mem_ack 1 cycle after each req, inst_ready=1 -> the bench SHALL see inst_addr 80000000, 80000004, 80000008 in order, with data matching memory.
REQ-036 inst_ready=0, DEPTH=4 -> the bench SHALL see exactly 4 requests, then mem_req stays low and count=4; one pop then triggers exactly one new request.
REQ-037 Redirect to 0x00001002 while in IDLE with the queue full -> the bench SHALL see inst_valid=0 next cycle, then the next mem_addr=0x00001000.
REQ-038 Redirect to 0x00000100 during REQ, with mem_ack held off 3 cycles -> the bench SHALL see the old mem_addr held until ack, no push of that data, then mem_addr=0x00000100.
REQ-039 Fetch at 0xFFFFFFFC -> the bench SHALL see a next mem_addr of 0x80000000 (bit 31 kept, low bits wrap).
REQ-040 RESET pulsed low during an outstanding request with 2 queued entries -> the bench SHALL see mem_req=0 and inst_valid=0 at once, then a restart fetch at RstAddr.
